// File: rtl/ddr_wburst_seq_pkg.sv
// ddr_wburst_seq_pkg
// Shared definitions for the DDR3 byte-lane write-burst sequencer.
// Contents:
//   SeqState        - sequencer FSM states (IDLE, WAIT, PRE, DATA, POST)
//   DQS_PAT_*       - DQS serializer data nibbles, bit 0 leaves the serializer first
//   TRI_*           - tristate nibbles for the DQS and DQ serializers, 1 = hi-Z
package ddr_wburst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PRE,
    DATA,
    POST
  } SeqState;

  localparam logic [3:0] DQS_PAT_IDLE = 4'b0000;
  localparam logic [3:0] DQS_PAT_PRE  = 4'b0000;
  localparam logic [3:0] DQS_PAT_DATA = 4'b1010;
  localparam logic [3:0] DQS_PAT_POST = 4'b0000;

  // Preamble releases hi-Z halfway through the cycle, postamble re-enters it halfway
  localparam logic [3:0] TRI_PRE  = 4'b0011;
  localparam logic [3:0] TRI_POST = 4'b1100;
  localparam logic [3:0] TRI_ON   = 4'b0000;
  localparam logic [3:0] TRI_OFF  = 4'b1111;

endpackage

// File: rtl/ddr_wburst_seq_if.sv
// ddr_wburst_seq_if
// Bundles the command handshake from the memory command sequencer and the
// nibble outputs toward the lane serializers / write buffer.
// Signals:
//   start   - one-cycle command pulse
//   nbursts - number of BL8 bursts minus 1, sampled with start
//   wlat    - cycles from start to preamble minus 1, sampled with start
//   busy    - sequence in progress
//   dq_re   - read strobe to the lane write buffer
//   dqs_din - DQS serializer data nibble
//   dqs_tin - DQS serializer tristate nibble
//   dq_tin  - DQ serializers tristate nibble
//   done    - one-cycle pulse in the postamble cycle
// Modports: master = command side, slave = sequencer side.
interface ddr_wburst_seq_if #(
  parameter int NB_WIDTH = 4,
  parameter int WL_WIDTH = 4
);

  logic                start;
  logic [NB_WIDTH-1:0] nbursts;
  logic [WL_WIDTH-1:0] wlat;
  logic                busy;
  logic                dq_re;
  logic [3:0]          dqs_din;
  logic [3:0]          dqs_tin;
  logic [3:0]          dq_tin;
  logic                done;

  modport master (
    output start, nbursts, wlat,
    input  busy, dq_re, dqs_din, dqs_tin, dq_tin, done
  );

  modport slave (
    input  start, nbursts, wlat,
    output busy, dq_re, dqs_din, dqs_tin, dq_tin, done
  );

endinterface

// File: rtl/ddr_wburst_seq.sv
// ddr_wburst_seq
// Write-burst sequencer for one DDR3 byte lane in the clk_div domain. Times
// write latency, DQS preamble, DQS toggling for N back-to-back BL8 bursts and
// the postamble, and reads the lane write buffer one cycle ahead of use.
// Ports:
//   clk - clk_div-domain clock
//   rst - synchronous active-high reset
//   bus - ddr_wburst_seq_if.slave (command in, serializer nibbles out)
// Configuration:
//   DDR_WBURST_GAPLESS_EN - when defined, a start in the last DATA cycle is
//   merged into the running burst without postamble/preamble.
module ddr_wburst_seq
  import ddr_wburst_seq_pkg::*;
#(
  parameter int NB_WIDTH = 4,
  parameter int WL_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ddr_wburst_seq_if.slave        bus
);

  localparam logic [WL_WIDTH-1:0] LAT_ONE = {{(WL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NB_WIDTH:0]   BEAT_ONE = {{NB_WIDTH{1'b0}}, 1'b1};

  SeqState             r_state;
  SeqState             w_stateNext;
  logic [WL_WIDTH-1:0] r_lat;
  logic [WL_WIDTH-1:0] w_latNext;
  logic [NB_WIDTH-1:0] r_nb;
  logic [NB_WIDTH-1:0] w_nbNext;
  logic [NB_WIDTH:0]   r_beat;
  logic [NB_WIDTH:0]   w_beatNext;
  logic                w_merge;

  logic                r_busy;
  logic                r_dqRe;
  logic                r_done;
  logic [3:0]          r_dqsDin;
  logic [3:0]          r_dqsTin;
  logic [3:0]          r_dqTin;

  logic                w_busy;
  logic                w_dqRe;
  logic                w_done;
  logic [3:0]          w_dqsDin;
  logic [3:0]          w_dqsTin;
  logic [3:0]          w_dqTin;

  // A follow-on command can only be merged while the last DATA beat is in
  // flight; otherwise the running burst ends normally with a postamble.
`ifdef DDR_WBURST_GAPLESS_EN
  assign w_merge = (r_state == DATA) && (r_beat == '0) && bus.start;
`else
  assign w_merge = 1'b0;
`endif

  // State and counter registers. The output nibbles lag the state by one
  // cycle, so the cycle right after start still shows idle outputs and the
  // preamble lands after edge wlat+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_nb    <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_lat   <= w_latNext;
      r_nb    <= w_nbNext;
      r_beat  <= w_beatNext;
    end
  end

  // Next-state logic and per-state output values. The beat counter is loaded
  // with 2*(nbursts+1)-1, which is simply nbursts with a 1 appended, so the
  // all-ones burst count still fits without wrapping. A start is refused
  // while the registered busy is still high from the postamble cycle.
  always_comb begin
    w_stateNext = r_state;
    w_latNext   = r_lat;
    w_nbNext    = r_nb;
    w_beatNext  = r_beat;
    w_busy      = 1'b0;
    w_dqRe      = 1'b0;
    w_done      = 1'b0;
    w_dqsDin    = DQS_PAT_IDLE;
    w_dqsTin    = TRI_OFF;
    w_dqTin     = TRI_OFF;
    unique case (r_state)
      IDLE: begin
        if (bus.start && !r_busy) begin
          w_nbNext    = bus.nbursts;
          w_latNext   = bus.wlat;
          w_stateNext = (bus.wlat != '0) ? WAIT : PRE;
        end
      end
      WAIT: begin
        w_busy    = 1'b1;
        w_latNext = r_lat - LAT_ONE;
        if (r_lat == LAT_ONE) begin
          w_stateNext = PRE;
        end
      end
      PRE: begin
        w_busy      = 1'b1;
        w_dqRe      = 1'b1;
        w_dqsDin    = DQS_PAT_PRE;
        w_dqsTin    = TRI_PRE;
        w_dqTin     = TRI_OFF;
        w_beatNext  = {r_nb, 1'b1};
        w_stateNext = DATA;
      end
      DATA: begin
        w_busy   = 1'b1;
        w_dqsDin = DQS_PAT_DATA;
        w_dqsTin = TRI_ON;
        w_dqTin  = TRI_ON;
        w_dqRe   = (r_beat != '0) || w_merge;
        if (w_merge) begin
          w_nbNext   = bus.nbursts;
          w_beatNext = {bus.nbursts, 1'b1};
        end else if (r_beat == '0) begin
          w_stateNext = POST;
        end else begin
          w_beatNext = r_beat - BEAT_ONE;
        end
      end
      POST: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_dqsDin    = DQS_PAT_POST;
        w_dqsTin    = TRI_POST;
        w_dqTin     = TRI_OFF;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Output registers; reset forces idle nibbles immediately with no postamble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_dqRe   <= 1'b0;
      r_done   <= 1'b0;
      r_dqsDin <= DQS_PAT_IDLE;
      r_dqsTin <= TRI_OFF;
      r_dqTin  <= TRI_OFF;
    end else begin
      r_busy   <= w_busy;
      r_dqRe   <= w_dqRe;
      r_done   <= w_done;
      r_dqsDin <= w_dqsDin;
      r_dqsTin <= w_dqsTin;
      r_dqTin  <= w_dqTin;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.dq_re   = r_dqRe;
  assign bus.done    = r_done;
  assign bus.dqs_din = r_dqsDin;
  assign bus.dqs_tin = r_dqsTin;
  assign bus.dq_tin  = r_dqTin;

endmodule
